// File: rtl/guitar_inject_sched.sv
// Strum-event queue that injects an addi score op plus a display-update op into the F/D slot.
// Optional combo bonus on the score immediate is enabled by defining GUITAR_COMBO_EN.
module guitar_inject_sched #(
    parameter int FIFO_DEPTH   = 4,
    parameter int SCORE_REG    = 2,
    parameter int UPDATE_REG   = 1,
    parameter int HIT_IMM      = 2,
    parameter int MISS_IMM     = 0,
    parameter int UPDATE_IMM   = 1,
    parameter int COMBO_THRESH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          strum,
    input  logic [3:0]                    buttons,
    input  logic [3:0]                    intersections,
    input  logic                          stall_in,
    input  logic                          flush_in,
    output logic                          inject_valid,
    output logic [31:0]                   inject_ir,
    output logic                          pc_hold,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
`ifdef GUITAR_COMBO_EN
    output logic [7:0]                    combo_count,
`endif
    output logic [7:0]                    drop_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [4:0]    SCORE_RD  = 5'(SCORE_REG);
    localparam logic [4:0]    UPDATE_RD = 5'(UPDATE_REG);
    localparam logic [16:0]   HIT_I     = 17'(HIT_IMM);
    localparam logic [16:0]   MISS_I    = 17'(MISS_IMM);
    localparam logic [16:0]   UPD_I     = 17'(UPDATE_IMM);
`ifdef GUITAR_COMBO_EN
    localparam logic [16:0]   BONUS_I   = 17'(HIT_IMM * 2);
    localparam logic [7:0]    COMBO_T   = 8'(COMBO_THRESH);
`endif

    typedef enum logic [1:0] {IDLE, OP, UPD} state_t;

    state_t          state_q, state_d;
    logic            strum_prev_q, strum_prev_d;
    logic            fifo_q [FIFO_DEPTH];
    logic            fifo_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      drop_q, drop_d;
    logic            cur_hit_q, cur_hit_d;
    logic            strum_edge, hit, full, pop, push, drop;
    logic [16:0]     op_imm;
`ifdef GUITAR_COMBO_EN
    logic [7:0]      combo_q, combo_d;
    logic            cur_bonus_q, cur_bonus_d;
`endif

    always_comb begin
        strum_edge   = strum & ~strum_prev_q;
        hit          = (buttons != '0) && (buttons == intersections);
        full         = (count_q == FULL_CNT);
        pop          = (state_q == IDLE) && (count_q != '0) && !stall_in;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        push         = strum_edge && (!full || pop);
        drop         = strum_edge && !push;

        strum_prev_d = strum;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cur_hit_d    = cur_hit_q;
        drop_d       = drop_q;
        state_d      = state_q;
`ifdef GUITAR_COMBO_EN
        combo_d      = combo_q;
        cur_bonus_d  = cur_bonus_q;
`endif

        if (push) begin
            fifo_d[wr_ptr_q] = hit;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            cur_hit_d = fifo_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
`ifdef GUITAR_COMBO_EN
            if (fifo_q[rd_ptr_q]) begin
                cur_bonus_d = (combo_q >= COMBO_T);
                combo_d     = (combo_q == 8'hff) ? combo_q : combo_q + 8'd1;
            end else begin
                cur_bonus_d = 1'b0;
                combo_d     = '0;
            end
`endif
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (drop && drop_q != 8'hff) drop_d = drop_q + 8'd1;

        case (state_q)
            IDLE:    if (pop) state_d = OP;
            OP:      if (!stall_in && !flush_in) state_d = UPD;
            UPD:     if (!stall_in && !flush_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef GUITAR_COMBO_EN
        op_imm = cur_hit_q ? (cur_bonus_q ? BONUS_I : HIT_I) : MISS_I;
`else
        op_imm = cur_hit_q ? HIT_I : MISS_I;
`endif
        inject_valid = (state_q != IDLE);
        pc_hold      = inject_valid;
        busy         = inject_valid;
        case (state_q)
            OP:      inject_ir = {5'b00101, SCORE_RD, 5'b00000, op_imm};
            UPD:     inject_ir = {5'b00101, UPDATE_RD, 5'b00000, UPD_I};
            default: inject_ir = '0;
        endcase
        pending    = count_q;
        drop_count = drop_q;
`ifdef GUITAR_COMBO_EN
        combo_count = combo_q;
`endif
    end

    // State updates on the falling edge to line up with the pipeline registers.
    always_ff @(negedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            strum_prev_q <= 1'b0;
            fifo_q       <= '{default: 1'b0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_q       <= '0;
            cur_hit_q    <= 1'b0;
`ifdef GUITAR_COMBO_EN
            combo_q      <= '0;
            cur_bonus_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            strum_prev_q <= strum_prev_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_q       <= drop_d;
            cur_hit_q    <= cur_hit_d;
`ifdef GUITAR_COMBO_EN
            combo_q      <= combo_d;
            cur_bonus_q  <= cur_bonus_d;
`endif
        end
    end
endmodule

// File: tb/tb_guitar_inject_sched.sv
// Directed bench for guitar_inject_sched; DUT state moves on negedge, bench drives/samples on posedge.
module tb_guitar_inject_sched;
    logic        clock = 1'b0;
    logic        reset, strum, stall_in, flush_in;
    logic [3:0]  buttons, intersections;
    logic        inject_valid, pc_hold, busy;
    logic [31:0] inject_ir;
    logic [2:0]  pending;
    logic [7:0]  drop_count;
`ifdef GUITAR_COMBO_EN
    logic [7:0]  combo_count;
`endif
    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] OP_HIT  = 32'h28800002;
    localparam logic [31:0] OP_MISS = 32'h28800000;
    localparam logic [31:0] UPD_IR  = 32'h28400001;

    always #5 clock = ~clock;

    guitar_inject_sched #(
        .FIFO_DEPTH(4), .SCORE_REG(2), .UPDATE_REG(1), .HIT_IMM(2),
        .MISS_IMM(0), .UPDATE_IMM(1), .COMBO_THRESH(4)
    ) dut (
        .clock(clock), .reset(reset), .strum(strum), .buttons(buttons),
        .intersections(intersections), .stall_in(stall_in), .flush_in(flush_in),
        .inject_valid(inject_valid), .inject_ir(inject_ir), .pc_hold(pc_hold),
        .busy(busy), .pending(pending),
`ifdef GUITAR_COMBO_EN
        .combo_count(combo_count),
`endif
        .drop_count(drop_count)
    );

    task automatic tick();
        @(posedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_inj(input string tag, input logic [31:0] exp_ir);
        check({tag, "_ir"}, inject_ir, exp_ir);
        check({tag, "_valid"}, {31'b0, inject_valid}, {31'b0, exp_ir != 32'h0});
        check({tag, "_hold"}, {31'b0, pc_hold}, {31'b0, exp_ir != 32'h0});
    endtask

    initial begin
        reset = 1'b1; strum = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
        buttons = 4'b0; intersections = 4'b0;
        tick(); tick();
        check_inj("rst", 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_pending", {29'b0, pending}, 32'h0);
        check("rst_drop", {24'b0, drop_count}, 32'h0);
        reset = 1'b0;
        tick();

        // Hit: OP one cycle, UPD one cycle, then idle
        buttons = 4'b0101; intersections = 4'b0101; strum = 1'b1;
        tick(); check("hit_pending", {29'b0, pending}, 32'd1); check_inj("hit_pre", 32'h0);
        tick(); check_inj("hit_op", OP_HIT); check("hit_pending_pop", {29'b0, pending}, 32'd0);
        tick(); check_inj("hit_upd", UPD_IR);
        tick(); check_inj("hit_done", 32'h0);
        tick(); tick();
        check_inj("hit_held_level", 32'h0);
        check("hit_held_pending", {29'b0, pending}, 32'd0);

        // Miss, with strum held high afterwards
        strum = 1'b0; tick();
        buttons = 4'b0001; intersections = 4'b0010; strum = 1'b1;
        tick(); check("miss_pending", {29'b0, pending}, 32'd1);
        tick(); check_inj("miss_op", OP_MISS);
        tick(); check_inj("miss_upd", UPD_IR);
        tick(); check_inj("miss_done", 32'h0);
        tick(); tick(); tick();
        check_inj("miss_held_level", 32'h0);
        check("miss_held_pending", {29'b0, pending}, 32'd0);

        // Stall three cycles in OP, flush one cycle in UPD
        strum = 1'b0; tick();
        buttons = 4'b0101; intersections = 4'b0101; strum = 1'b1;
        tick();
        tick(); check_inj("stall_op0", OP_HIT); stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_inj("stall_op", OP_HIT);
        end
        stall_in = 1'b0;
        tick(); check_inj("flush_upd0", UPD_IR); flush_in = 1'b1;
        tick(); check_inj("flush_upd1", UPD_IR); flush_in = 1'b0;
        tick(); check_inj("flush_done", 32'h0);

        // Overflow: six edges under stall into a depth-4 queue
        strum = 1'b0; stall_in = 1'b1; tick();
        for (int i = 0; i < 6; i++) begin
            strum = 1'b1; tick();
            strum = 1'b0; tick();
        end
        check("ovf_pending", {29'b0, pending}, 32'd4);
        check("ovf_drop", {24'b0, drop_count}, 32'd2);
        check_inj("ovf_stalled", 32'h0);
        // Release stall together with a new edge: push while full plus pop is accepted
        stall_in = 1'b0; strum = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(); check_inj("drain_op", OP_HIT);
            check("drain_pending", {29'b0, pending}, (k == 0) ? 32'd4 : 32'(4 - k));
            tick(); check_inj("drain_upd", UPD_IR);
            tick(); check_inj("drain_gap", 32'h0);
        end
        check("drain_drop", {24'b0, drop_count}, 32'd2);

        // Reset during UPD
        strum = 1'b0; tick();
        strum = 1'b1; tick();
        tick(); check_inj("rmid_op", OP_HIT);
        tick(); check_inj("rmid_upd", UPD_IR);
        reset = 1'b1; strum = 1'b0;
        tick();
        check_inj("rmid_rst", 32'h0);
        check("rmid_pending", {29'b0, pending}, 32'd0);
        check("rmid_drop", {24'b0, drop_count}, 32'd0);
        check("rmid_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;
        tick(); check_inj("rmid_after1", 32'h0);
        tick(); check_inj("rmid_after2", 32'h0);

`ifdef GUITAR_COMBO_EN
        buttons = 4'b0101; intersections = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            strum = 1'b1; tick();
            tick(); check_inj("combo_op", (k == 4) ? 32'h28800004 : OP_HIT);
            tick(); strum = 1'b0;
            tick();
        end
        check("combo_five", {24'b0, combo_count}, 32'd5);
        buttons = 4'b0001; intersections = 4'b0010; strum = 1'b1;
        tick();
        tick(); check_inj("combo_miss_op", OP_MISS);
        check("combo_cleared", {24'b0, combo_count}, 32'd0);
        tick(); tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
